spk_out_buf: RTL and testbench

- Spike output stage, directly downstream of the neuron work controller and soma.
- Captures each fired neuron's global ID, aligned with the soma fire flag, into a FIFO.
- Applies the per-node destination offset and sends one flit per spike to the router over a valid/ready handshake.
- Back-pressures the work controller via spk_out_config_full, with margin for its in-flight pipeline.

---
 rtl/spk_pkg.sv | 25 ++
 rtl/spk_out_buf_if.sv | 8 +
 rtl/spk_out_buf_fifo.sv | 45 ++++
 rtl/spk_out_buf.sv | 132 +++++++++++++
 tb/tb_spk_out_buf.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spk_pkg.sv
// spk_pkg: flit types, FSM states and {z,y,x} offset adder for spk_out_buf (S_EOT only with SPK_OUT_EOT_EN)
package spk_pkg;
  localparam logic [1:0] SPK_T_SPIKE = 2'b00;
  localparam logic [1:0] SPK_T_EOT   = 2'b11;
  localparam int SPK_MAXW = 96;
`ifdef SPK_OUT_EOT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_EOT = 2'd3} spk_state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} spk_state_e;
`endif
  // Adds three packed sw/3-bit fields independently; carries never cross into the next field.
  function automatic logic [SPK_MAXW-1:0] spk_add_zyx(input logic [SPK_MAXW-1:0] a,
                                                      input logic [SPK_MAXW-1:0] b,
                                                      input int sw);
    logic [SPK_MAXW-1:0] m;
    logic [SPK_MAXW-1:0] r;
    int f;
    f = sw / 3;
    m = (SPK_MAXW'(1) << f) - SPK_MAXW'(1);
    r = '0;
    for (int i = 0; i < 3; i++)
      r = r | (((((a >> (i * f)) & m) + ((b >> (i * f)) & m)) & m) << (i * f));
    return r;
  endfunction
endpackage

// File: rtl/spk_out_buf_if.sv
// spk_out_buf_if: valid/ready flit channel from spk_out_buf to the router
interface spk_out_buf_if #(parameter int PW = 26);
  logic          pkt_vld;
  logic [PW-1:0] pkt_data;
  logic          pkt_rdy;
  modport master (output pkt_vld, output pkt_data, input pkt_rdy);
  modport slave  (input pkt_vld, input pkt_data, output pkt_rdy);
endinterface

// File: rtl/spk_out_buf_fifo.sv
// spk_fifo: synchronous FIFO with look-ahead head, occupancy count and synchronous clear
module spk_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 24,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         wr_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_i,
  output logic [W-1:0] rd_data_o,
  output logic [AW:0]  count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   count_q;
  logic          do_wr, do_rd;

  assign do_wr     = wr_i && count_q != (AW+1)'(DEPTH);
  assign do_rd     = rd_i && count_q != '0;
  assign rd_data_o = mem_q[rp_q];
  assign count_o   = count_q;

  // Pointers and occupancy; clear empties the queue without touching storage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_q + AW'(do_wr);
      rp_q    <= rp_q + AW'(do_rd);
      count_q <= count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

  // Storage array
  always_ff @(posedge clk)
    if (do_wr) mem_q[wp_q] <= wr_data_i;
endmodule

// File: rtl/spk_out_buf.sv
// spk_out_buf: offsets fired neuron IDs, buffers them and streams spike flits to the router; SPK_OUT_EOT_EN appends an end-of-tik flit after each drain
module spk_out_buf
  import spk_pkg::*;
#(
  parameter int SW          = 24,
  parameter int DEPTH       = 16,
  parameter int FULL_MARGIN = 4,
  parameter int CW          = 16,
  localparam int PW         = SW + 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            config_enable,
  input  logic            work_config_busy,
  input  logic            soma_spk_vld,
  input  logic [SW-1:0]   config_spk_out_neuid,
  input  logic [SW/3-1:0] dst_dx,
  input  logic [SW/3-1:0] dst_dy,
  input  logic [SW/3-1:0] dst_dz,
  output logic            spk_out_config_full,
  spk_out_buf_if.master   pkt,
  output logic [CW-1:0]   spk_cnt,
  output logic            spk_ovf,
  output logic            spk_out_busy
);
  localparam int AW = $clog2(DEPTH);

  spk_state_e    state_q, state_d;
  logic          busy_q, pend_q, pend_d, ovf_q, ovf_d, vld_q, vld_d;
  logic [PW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] dst, head;
  logic [AW:0]   fcnt;
  logic          fempty, accept, load, bypass, rise, drained, eot_load;

  assign dst    = SW'(spk_add_zyx(SPK_MAXW'(config_spk_out_neuid), SPK_MAXW'({dst_dz, dst_dy, dst_dx}), SW));
  assign fempty = fcnt == '0;
  assign accept = config_enable && soma_spk_vld && fcnt != (AW+1)'(DEPTH);
  assign load   = !vld_q || pkt.pkt_rdy;
  assign bypass = accept && fempty && load;
  assign rise   = work_config_busy && !busy_q;
  assign drained = fempty && !vld_q && !soma_spk_vld;

  assign spk_out_config_full = fcnt >= (AW+1)'(DEPTH - FULL_MARGIN);
  assign pkt.pkt_vld  = vld_q;
  assign pkt.pkt_data = data_q;
  assign spk_cnt      = cnt_q;
  assign spk_ovf      = ovf_q;
  assign spk_out_busy = state_q != S_IDLE || !fempty || vld_q;

  spk_fifo #(.DEPTH(DEPTH), .W(SW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (!config_enable),
    .wr_i      (accept && !bypass),
    .wr_data_i (dst),
    .rd_i      (config_enable && load && !fempty),
    .rd_data_o (head),
    .count_o   (fcnt)
  );

  // Tik sequencing: restart requests arriving while draining are held until idle
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q || (rise && state_q != S_IDLE && state_q != S_RUN);
    eot_load = 1'b0;
    case (state_q)
      S_IDLE:  if (rise || pend_q) begin
        state_d = S_RUN;
        pend_d  = 1'b0;
      end
      S_RUN:   if (!work_config_busy) state_d = S_DRAIN;
      S_DRAIN: if (drained) begin
`ifdef SPK_OUT_EOT_EN
        state_d  = S_EOT;
        eot_load = 1'b1;
`else
        state_d  = S_IDLE;
`endif
      end
`ifdef SPK_OUT_EOT_EN
      S_EOT:   if (vld_q && pkt.pkt_rdy) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
    if (!config_enable) begin
      state_d  = S_IDLE;
      pend_d   = 1'b0;
      eot_load = 1'b0;
    end
  end

  // Output register (FIFO head, or the incoming spike when nothing is queued), overflow flag and tik spike counter
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (eot_load) begin
      vld_d  = 1'b1;
      data_d = {SPK_T_EOT, dst_dz, dst_dy, dst_dx};
    end else if (load) begin
      vld_d  = bypass || !fempty;
      data_d = !fempty ? {SPK_T_SPIKE, head} : bypass ? {SPK_T_SPIKE, dst} : data_q;
    end
    ovf_d = ovf_q || (config_enable && soma_spk_vld && !accept);
    cnt_d = (state_q == S_IDLE && state_d == S_RUN) ? '0 :
            (accept && (state_q == S_RUN || state_q == S_DRAIN) && cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
    if (!config_enable) begin
      vld_d = 1'b0;
      ovf_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= work_config_busy;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
endmodule

// File: tb/tb_spk_out_buf.sv
// tb_spk_out_buf: randomized self-checking bench for spk_out_buf against a flit-queue reference model
module tb_spk_out_buf;
  localparam int SW = 24, DEPTH = 16, FM = 4, CW = 16, PW = SW + 2;

  logic          clk = 1'b0;
  logic          rst_n, config_enable, work_config_busy, soma_spk_vld;
  logic [SW-1:0] neuid;
  logic [7:0]    dx, dy, dz;
  logic          full, ovf, busy_o;
  logic [CW-1:0] cnt;

  spk_out_buf_if #(.PW(PW)) pkt_if ();

  spk_out_buf #(.SW(SW), .DEPTH(DEPTH), .FULL_MARGIN(FM), .CW(CW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .config_enable        (config_enable),
    .work_config_busy     (work_config_busy),
    .soma_spk_vld         (soma_spk_vld),
    .config_spk_out_neuid (neuid),
    .dst_dx               (dx),
    .dst_dy               (dy),
    .dst_dz               (dz),
    .spk_out_config_full  (full),
    .pkt                  (pkt_if),
    .spk_cnt              (cnt),
    .spk_ovf              (ovf),
    .spk_out_busy         (busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: every accepted, not yet handshaken flit in arrival order (head is what the router sees)
  logic [PW-1:0] mq[$];
  bit            ovf_m;
  int            n_chk = 0, n_fail = 0;

  function automatic logic [PW-1:0] exp_flit(input logic [SW-1:0] id, input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    int fx, fy, fz;
    fx = (int'(id[7:0]) + int'(x)) % 256;
    fy = (int'(id[15:8]) + int'(y)) % 256;
    fz = (int'(id[23:16]) + int'(z)) % 256;
    return {2'b00, 8'(fz), 8'(fy), 8'(fx)};
  endfunction

  function automatic int model_fcnt();
    return mq.size() > 0 ? mq.size() - 1 : 0;
  endfunction

  // Advance the model with the inputs currently applied, then let the DUT take the same edge
  task automatic tick();
    int fc;
    fc = model_fcnt();
    if (!config_enable) begin
      mq.delete();
      ovf_m = 1'b0;
    end else begin
      if (mq.size() > 0 && pkt_if.pkt_rdy) void'(mq.pop_front());
      if (soma_spk_vld && fc < DEPTH) mq.push_back(exp_flit(neuid, dx, dy, dz));
      else if (soma_spk_vld) ovf_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic spike(input bit v);
    soma_spk_vld = v;
    neuid = SW'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; config_enable = 1'b1; work_config_busy = 1'b0; soma_spk_vld = 1'b0;
    neuid = '0; dx = '0; dy = '0; dz = '0; pkt_if.pkt_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (pkt_if.pkt_vld !== 1'b0 || pkt_if.pkt_data !== '0) begin
      n_fail++; $display("FAIL reset_flit vld=%0b data=%h exp 0/0", pkt_if.pkt_vld, pkt_if.pkt_data);
    end
    n_chk++;
    if ({full, cnt, ovf, busy_o} !== '0) begin
      n_fail++; $display("FAIL reset_status full=%0b cnt=%0d ovf=%0b busy=%0b exp all 0", full, cnt, ovf, busy_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_offset_wrap();
    dx = 8'd10; dy = 8'd1; dz = 8'd0;
    pkt_if.pkt_rdy = 1'b0;
    soma_spk_vld = 1'b1; neuid = {8'd3, 8'd5, 8'd250};
    tick();
    soma_spk_vld = 1'b0;
    n_chk++;
    if (pkt_if.pkt_vld !== 1'b1 || pkt_if.pkt_data !== {2'b00, 8'd3, 8'd6, 8'd4}) begin
      n_fail++; $display("FAIL offset_wrap vld=%0b data=%h exp 1/%h", pkt_if.pkt_vld, pkt_if.pkt_data, {2'b00, 8'd3, 8'd6, 8'd4});
    end
    pkt_if.pkt_rdy = 1'b1;
    tick();
    n_chk++;
    if (pkt_if.pkt_vld !== 1'b0 || cnt !== '0) begin
      n_fail++; $display("FAIL offset_consume vld=%0b cnt=%0d exp 0/0 (idle spike uncounted)", pkt_if.pkt_vld, cnt);
    end
  endtask

  task automatic test_backpressure();
    bit done;
    dx = 8'($urandom); dy = 8'($urandom); dz = 8'($urandom);
    pkt_if.pkt_rdy = 1'b0;
    work_config_busy = 1'b1;
    tick();
    for (int i = 0; i < 18; i++) begin
      spike(1'b1);
      tick();
      n_chk++;
      if (full !== (model_fcnt() >= DEPTH - FM) || ovf !== ovf_m) begin
        n_fail++; $display("FAIL bp_full i=%0d full=%0b ovf=%0b exp %0b/%0b", i, full, ovf, model_fcnt() >= DEPTH - FM, ovf_m);
      end
    end
    spike(1'b0);
    n_chk++;
    if (cnt !== 16'd17 || ovf !== 1'b1 || full !== 1'b1) begin
      n_fail++; $display("FAIL bp_final cnt=%0d ovf=%0b full=%0b exp 17/1/1", cnt, ovf, full);
    end
    pkt_if.pkt_rdy = 1'b1;
    for (int i = 0; i < 40 && mq.size() > 0; i++) begin
      tick();
      n_chk++;
      if (pkt_if.pkt_vld !== (mq.size() > 0) || (mq.size() > 0 && pkt_if.pkt_data !== mq[0])) begin
        n_fail++; $display("FAIL bp_drain i=%0d vld=%0b data=%h exp_vld=%0b", i, pkt_if.pkt_vld, pkt_if.pkt_data, mq.size() > 0);
      end
    end
    work_config_busy = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = busy_o == 1'b0;
    end
    n_chk++;
    if (!done) begin
      n_fail++; $display("FAIL bp_idle busy=%0b exp 0 within 20 cycles", busy_o);
    end
  endtask

  task automatic test_flush();
    pkt_if.pkt_rdy = 1'b0;
    work_config_busy = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      spike(1'b1);
      tick();
    end
    spike(1'b0);
    n_chk++;
    if (dut.fcnt !== 5'd7 || pkt_if.pkt_vld !== 1'b1 || cnt !== 16'd8) begin
      n_fail++; $display("FAIL flush_pre count=%0d vld=%0b cnt=%0d exp 7/1/8", dut.fcnt, pkt_if.pkt_vld, cnt);
    end
    config_enable = 1'b0;
    tick();
    config_enable = 1'b1;
    n_chk++;
    if (pkt_if.pkt_vld !== 1'b0 || dut.fcnt !== '0 || ovf !== 1'b0 || busy_o !== 1'b0 || full !== 1'b0) begin
      n_fail++; $display("FAIL flush vld=%0b count=%0d ovf=%0b busy=%0b full=%0b exp all 0", pkt_if.pkt_vld, dut.fcnt, ovf, busy_o, full);
    end
    n_chk++;
    if (cnt !== 16'd8) begin
      n_fail++; $display("FAIL flush_cnt_hold cnt=%0d exp 8", cnt);
    end
    work_config_busy = 1'b0;
    tick();
  endtask

  task automatic test_stall_hold();
    logic [3:0]    pat;
    logic          pv, pr;
    logic [PW-1:0] pd;
    pat = 4'b1001;
    dx = 8'($urandom); dy = 8'($urandom); dz = 8'($urandom);
    for (int i = 0; i < 64; i++) begin
      pkt_if.pkt_rdy = pat[i % 4];
      spike(1'($urandom_range(0, 1)));
      pv = pkt_if.pkt_vld; pd = pkt_if.pkt_data; pr = pkt_if.pkt_rdy;
      tick();
      n_chk++;
      if (pkt_if.pkt_vld !== (mq.size() > 0) || (mq.size() > 0 && pkt_if.pkt_data !== mq[0])) begin
        n_fail++; $display("FAIL stall_flit i=%0d vld=%0b data=%h exp_vld=%0b", i, pkt_if.pkt_vld, pkt_if.pkt_data, mq.size() > 0);
      end
      if (pv && !pr) begin
        n_chk++;
        if (pkt_if.pkt_vld !== 1'b1 || pkt_if.pkt_data !== pd) begin
          n_fail++; $display("FAIL stall_hold i=%0d vld=%0b data=%h exp 1/%h", i, pkt_if.pkt_vld, pkt_if.pkt_data, pd);
        end
      end
    end
    spike(1'b0);
    pkt_if.pkt_rdy = 1'b1;
    for (int i = 0; i < 40 && mq.size() > 0; i++) tick();
    tick();
    n_chk++;
    if (pkt_if.pkt_vld !== 1'b0 || mq.size() != 0) begin
      n_fail++; $display("FAIL stall_empty vld=%0b model_left=%0d exp 0/0", pkt_if.pkt_vld, mq.size());
    end
  endtask

  task automatic test_back_to_back();
    pkt_if.pkt_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      spike(1'b1);
      tick();
    end
    pkt_if.pkt_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      spike(1'b1);
      tick();
      n_chk++;
      if (dut.fcnt !== 5'd5 || full !== 1'b0 || pkt_if.pkt_vld !== 1'b1 || pkt_if.pkt_data !== mq[0]) begin
        n_fail++; $display("FAIL b2b i=%0d count=%0d full=%0b vld=%0b data=%h exp 5/0/1/%h", i, dut.fcnt, full, pkt_if.pkt_vld, pkt_if.pkt_data, mq[0]);
      end
    end
    spike(1'b0);
    for (int i = 0; i < 20 && mq.size() > 0; i++) tick();
    tick();
  endtask

  task automatic test_pending_restart();
    bit seen;
    pkt_if.pkt_rdy = 1'b0;
    work_config_busy = 1'b1;
    tick();
    spike(1'b1); tick();
    spike(1'b1); tick();
    spike(1'b0);
    work_config_busy = 1'b0; tick();
    work_config_busy = 1'b1; tick();
    n_chk++;
    if (cnt !== 16'd2 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL pend_pre cnt=%0d busy=%0b exp 2/1", cnt, busy_o);
    end
    pkt_if.pkt_rdy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      seen = cnt == '0;
    end
    n_chk++;
    if (!seen) begin
      n_fail++; $display("FAIL pend_restart cnt=%0d exp 0 within 12 cycles", cnt);
    end
    spike(1'b1); tick(); spike(1'b0);
    n_chk++;
    if (cnt !== 16'd1 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL pend_count cnt=%0d busy=%0b exp 1/1", cnt, busy_o);
    end
    work_config_busy = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = busy_o == 1'b0;
    end
    n_chk++;
    if (!seen) begin
      n_fail++; $display("FAIL pend_idle busy=%0b exp 0 within 20 cycles", busy_o);
    end
  endtask

`ifdef SPK_OUT_EOT_EN
  task automatic test_eot();
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] got_q[$];
    dx = 8'($urandom); dy = 8'($urandom); dz = 8'($urandom);
    pkt_if.pkt_rdy = 1'b1;
    work_config_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      spike(i == 2 || i == 4 || i == 6);
      if (soma_spk_vld) exp_q.push_back(exp_flit(neuid, dx, dy, dz));
      tick();
      if (pkt_if.pkt_vld) got_q.push_back(pkt_if.pkt_data);
    end
    spike(1'b0);
    work_config_busy = 1'b0;
    exp_q.push_back({2'b11, dz, dy, dx});
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pkt_if.pkt_vld) got_q.push_back(pkt_if.pkt_data);
    end
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL eot_count flits=%0d exp %0d", got_q.size(), exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++) begin
        n_chk++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL eot_flit i=%0d data=%h exp %h", i, got_q[i], exp_q[i]);
        end
      end
    n_chk++;
    if (busy_o !== 1'b0 || cnt !== 16'd3) begin
      n_fail++; $display("FAIL eot_end busy=%0b cnt=%0d exp 0/3", busy_o, cnt);
    end
    mq.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_offset_wrap();
    test_backpressure();
    test_flush();
    test_stall_hold();
    test_back_to_back();
    test_pending_restart();
`ifdef SPK_OUT_EOT_EN
    test_eot();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end
endmodule
